// File: rtl/mfcc_pkg.sv
// Shared types and defaults for the MFCC front end.
// Used by power_spectrum and frame_bin_counter.
package mfcc_pkg;

    localparam int N_FFT_DEFAULT = 512;
    localparam int FFT_IN_WIDTH  = 16;
    localparam int POWER_WIDTH   = 32;

    typedef struct packed {
        logic signed [FFT_IN_WIDTH-1:0] re;
        logic signed [FFT_IN_WIDTH-1:0] im;
    } complex_sample_t;

    // Counter width that stays at least one bit for tiny frames.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_bin_counter.sv
// Modulo-N_FFT bin counter producing the per-beat last tag.
// Optional frame-length check: POWER_SPECTRUM_FRAME_CHECK_EN.
module frame_bin_counter
    import mfcc_pkg::*;
#(
    parameter int N_FFT = N_FFT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  logic i_last,
    output logic o_last_tag,
    output logic o_frame_error
);

    localparam int CW = cnt_width(N_FFT);
    localparam logic [CW-1:0] LAST_BIN = CW'(N_FFT - 1);

    logic [CW-1:0] r_bin;
    logic          w_at_end;
    logic          w_next_zero;

    assign w_at_end = (r_bin == LAST_BIN);

`ifdef POWER_SPECTRUM_FRAME_CHECK_EN
    logic r_err;
    logic w_early;

    // An early last closes the frame on this beat.
    assign w_early       = i_last && !w_at_end;
    assign o_last_tag    = w_at_end || w_early;
    assign w_next_zero   = w_at_end || w_early;
    assign o_frame_error = r_err;

    // Sticky flag: any transfer whose last marker disagrees with the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (i_push && (i_last != w_at_end)) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = i_last;
    assign o_last_tag    = w_at_end;
    assign w_next_zero   = w_at_end;
    assign o_frame_error = 1'b0;
`endif

    // Advance one bin per accepted beat, wrapping at frame end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin <= '0;
        end else if (i_push) begin
            r_bin <= w_next_zero ? '0 : r_bin + 1'b1;
        end
    end

endmodule

// File: rtl/power_spectrum.sv
// Streaming |X|^2 stage: two-register pipeline with backpressure.
// Frame-length checking is enabled by POWER_SPECTRUM_FRAME_CHECK_EN.
module power_spectrum
    import mfcc_pkg::*;
#(
    parameter int N_FFT     = N_FFT_DEFAULT,
    parameter int IN_WIDTH  = FFT_IN_WIDTH,
    parameter int OUT_WIDTH = POWER_WIDTH,
    parameter int SHIFT     = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [2*IN_WIDTH-1:0] fft_data_in,
    input  logic                  fft_valid_in,
    input  logic                  fft_last_in,
    output logic                  fft_ready_out,
    output logic [OUT_WIDTH-1:0]  power_data_out,
    output logic                  power_valid_out,
    output logic                  power_last_out,
    input  logic                  power_ready_in,
    output logic                  frame_error_out
);

    localparam int PW = 2 * IN_WIDTH;
    localparam int SW = PW + 1;

    logic                        w_en;
    logic                        w_push;
    logic                        w_last_tag;
    logic signed [IN_WIDTH-1:0]  w_re;
    logic signed [IN_WIDTH-1:0]  w_im;
    logic signed [PW-1:0]        w_re_sq;
    logic signed [PW-1:0]        w_im_sq;
    logic [SW-1:0]               w_sum;
    logic [SW-1:0]               w_shr;
    logic [OUT_WIDTH-1:0]        w_sat;

    logic                        r_s1_valid;
    logic                        r_s1_last;
    logic [PW-1:0]               r_s1_re_sq;
    logic [PW-1:0]               r_s1_im_sq;

    logic                        r_s2_valid;
    logic                        r_s2_last;
    logic [OUT_WIDTH-1:0]        r_s2_data;

    assign w_en          = !r_s2_valid || power_ready_in;
    assign fft_ready_out = w_en && rst_n_in;
    assign w_push        = fft_valid_in && fft_ready_out;

    assign w_re    = fft_data_in[PW-1:IN_WIDTH];
    assign w_im    = fft_data_in[IN_WIDTH-1:0];
    assign w_re_sq = w_re * w_re;
    assign w_im_sq = w_im * w_im;

    // Squares are non-negative, so zero-extension is exact.
    assign w_sum = {1'b0, r_s1_re_sq} + {1'b0, r_s1_im_sq};
    assign w_shr = w_sum >> SHIFT;

    generate
        if (OUT_WIDTH >= SW) begin : g_wide
            assign w_sat = OUT_WIDTH'(w_shr);
        end else begin : g_sat
            assign w_sat = (|w_shr[SW-1:OUT_WIDTH]) ? '1
                                                    : w_shr[OUT_WIDTH-1:0];
        end
    endgenerate

    frame_bin_counter #(
        .N_FFT(N_FFT)
    ) u_cnt (
        .i_clk        (clk_in),
        .i_rst_n      (rst_n_in),
        .i_push       (w_push),
        .i_last       (fft_last_in),
        .o_last_tag   (w_last_tag),
        .o_frame_error(frame_error_out)
    );

    // Stage 1: squares, valid and last tag of the accepted beat.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_re_sq <= '0;
            r_s1_im_sq <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_push;
            r_s1_last  <= w_last_tag;
            r_s1_re_sq <= w_re_sq;
            r_s1_im_sq <= w_im_sq;
        end
    end

    // Stage 2: summed, shifted, saturated power presented downstream.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid && r_s1_last;
            r_s2_data  <= w_sat;
        end
    end

    assign power_data_out  = r_s2_data;
    assign power_valid_out = r_s2_valid;
    assign power_last_out  = r_s2_last;

endmodule

// File: tb/tb_power_spectrum.sv
// Bench for power_spectrum: directed stimulus, queue-based power model.
// Three instances share stimulus: defaults, SHIFT=4 and OUT_WIDTH=16.
module tb_power_spectrum;

    localparam int N = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        vin;
    logic        lin;
    logic        rdy;

    logic        rdy0, pv0, pl0, pe0;
    logic [31:0] pd0;
    logic        rdy_s, pv_s, pl_s, pe_s;
    logic [31:0] pd_s;
    logic        rdy_o, pv_o, pl_o, pe_o;
    logic [15:0] pd_o;

    always #5 clk = ~clk;

    power_spectrum dut0 (
        .clk_in(clk), .rst_n_in(rst_n),
        .fft_data_in(din), .fft_valid_in(vin), .fft_last_in(lin),
        .fft_ready_out(rdy0),
        .power_data_out(pd0), .power_valid_out(pv0),
        .power_last_out(pl0), .power_ready_in(rdy),
        .frame_error_out(pe0)
    );

    power_spectrum #(.SHIFT(4)) dut_s (
        .clk_in(clk), .rst_n_in(rst_n),
        .fft_data_in(din), .fft_valid_in(vin), .fft_last_in(lin),
        .fft_ready_out(rdy_s),
        .power_data_out(pd_s), .power_valid_out(pv_s),
        .power_last_out(pl_s), .power_ready_in(rdy),
        .frame_error_out(pe_s)
    );

    power_spectrum #(.OUT_WIDTH(16)) dut_o (
        .clk_in(clk), .rst_n_in(rst_n),
        .fft_data_in(din), .fft_valid_in(vin), .fft_last_in(lin),
        .fft_ready_out(rdy_o),
        .power_data_out(pd_o), .power_valid_out(pv_o),
        .power_last_out(pl_o), .power_ready_in(rdy),
        .frame_error_out(pe_o)
    );

    typedef struct {
        longint p0;
        longint ps;
        longint po;
        logic   last;
        longint l0;
        longint ls;
        longint lo;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    int     vectors = 0;
    int     fails = 0;
    int     cyc = 0;
    int     n_pop = 0;
    int     n_last = 0;
    int     last_idx = -1;
    int     model_bin = 0;
    logic   model_err = 1'b0;
    bit     lat_mode = 1'b1;
    bit     hold_prev = 1'b0;
    longint lit0 = -1;
    longint lit_s = -1;
    longint lit_o = -1;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic longint pw(input int re, input int im,
                                  input int sh, input int ow);
        longint s;
        longint mx;
        s  = longint'(re) * re + longint'(im) * im;
        s  = s >>> sh;
        mx = (longint'(1) << ow) - 1;
        return (s > mx) ? mx : s;
    endfunction

    // Compare process: outputs and inputs are stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   re_v;
        int   im_v;
        bit   at_end;
        cyc++;
        if (!rst_n) begin
            chk("rst_valid", pv0, 0);
            chk("rst_last", pl0, 0);
            chk("rst_data", pd0, 0);
            chk("rst_err", pe0, 0);
            chk("rst_ready", rdy0, 0);
            q.delete();
            model_bin = 0;
            model_err = 1'b0;
            n_pop     = 0;
            n_last    = 0;
            last_idx  = -1;
            hold_prev = 1'b0;
        end else begin
            chk("ready", rdy0, !pv0 || rdy);
            chk("ready_s", rdy_s, !pv_s || rdy);
            chk("ready_o", rdy_o, !pv_o || rdy);
            chk("err", pe0, model_err);
            chk("err_s", pe_s, model_err);
            chk("err_o", pe_o, model_err);
            if (hold_prev) chk("stall_hold_valid", pv0, 1);
            if (pv0 && rdy) begin
                if (q.size() == 0) begin
                    chk("spurious_out", pv0, 0);
                end else begin
                    e = q.pop_front();
                    chk("data", pd0, e.p0);
                    chk("last", pl0, e.last);
                    chk("valid_s", pv_s, 1);
                    chk("data_s", pd_s, e.ps);
                    chk("last_s", pl_s, e.last);
                    chk("valid_o", pv_o, 1);
                    chk("data_o", pd_o, e.po);
                    chk("last_o", pl_o, e.last);
                    if (e.l0 >= 0) chk("lit_data", pd0, e.l0);
                    if (e.ls >= 0) chk("lit_data_s", pd_s, e.ls);
                    if (e.lo >= 0) chk("lit_data_o", pd_o, e.lo);
                    if (lat_mode) chk("latency", cyc - e.cyc, 2);
                    if (pl0) begin
                        last_idx = n_pop;
                        n_last++;
                    end
                    n_pop++;
                end
            end
            if (vin && rdy0) begin
                re_v   = int'($signed(din[31:16]));
                im_v   = int'($signed(din[15:0]));
                e.p0   = pw(re_v, im_v, 0, 32);
                e.ps   = pw(re_v, im_v, 4, 32);
                e.po   = pw(re_v, im_v, 0, 16);
                e.l0   = lit0;
                e.ls   = lit_s;
                e.lo   = lit_o;
                e.cyc  = cyc;
                at_end = (model_bin == N - 1);
                e.last = at_end;
`ifdef POWER_SPECTRUM_FRAME_CHECK_EN
                if (lin != at_end) model_err = 1'b1;
                if (lin && !at_end) begin
                    e.last    = 1'b1;
                    model_bin = 0;
                end else begin
                    model_bin = at_end ? 0 : model_bin + 1;
                end
`else
                model_bin = at_end ? 0 : model_bin + 1;
`endif
                q.push_back(e);
            end
            hold_prev = pv0 && !rdy;
        end
    end

    task automatic send(input int re, input int im, input bit last,
                        input longint l0, input longint ls, input longint lo);
        int g;
        din   = {re[15:0], im[15:0]};
        vin   = 1'b1;
        lin   = last;
        lit0  = l0;
        lit_s = ls;
        lit_o = lo;
        g = 0;
        @(negedge clk);
        while (!rdy0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("accept_timeout", g, 0);
        @(posedge clk);
        #1;
        vin   = 1'b0;
        lin   = 1'b0;
        lit0  = -1;
        lit_s = -1;
        lit_o = -1;
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vin   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_lo;
        rst_n = 1'b0;
        din   = '0;
        vin   = 1'b0;
        lin   = 1'b0;
        rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant 3+4j frame: 25 on every bin, last only on bin 511.
        for (int i = 0; i < N; i++) send(3, 4, i == N - 1, 25, 1, 25);
        idle(6);
        chk("t1_count", n_pop, 512);
        chk("t1_last_idx", last_idx, 511);
        chk("t1_lasts", n_last, 1);

        // Corner magnitudes, with a bubble in between.
        do_reset();
        send(-32768, -32768, 1'b0, 64'h8000_0000, 64'h0800_0000, 65535);
        idle(2);
        send(0, -1, 1'b0, 1, 0, 1);
        send(256, 256, 1'b0, 131072, 8192, 65535);
        send(32767, 32767, 1'b0, 2147352578, 134209536, 65535);
        send(-5, 12, 1'b0, 169, 10, 169);
        idle(6);
        chk("t2_count", n_pop, 5);

        // Ramp with a five-cycle downstream stall at output 100.
        do_reset();
        lat_mode = 1'b0;
        stall_lo = 0;
        fork
            begin
                for (int i = 0; i < N; i++)
                    send(i, 0, i == N - 1, longint'(i) * i, -1, -1);
            end
            begin
                for (int k = 0; k < 5000; k++) begin
                    @(posedge clk);
                    #1;
                    if (n_pop >= 100) break;
                end
                rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!rdy0) stall_lo++;
                end
                @(posedge clk);
                #1;
                rdy = 1'b1;
            end
        join
        idle(8);
        chk("t3_stall_ready_low", stall_lo, 5);
        chk("t3_count", n_pop, 512);
        chk("t3_last_idx", last_idx, 511);
        lat_mode = 1'b1;

        // Early last marker on beat 99, then a full frame.
        do_reset();
        for (int i = 0; i < 100; i++) send(i + 1, 1, i == 99, -1, -1, -1);
        for (int j = 0; j < N; j++) send(7, -7, j == N - 1, 98, 6, 98);
        idle(6);
        chk("t4_count", n_pop, 612);
`ifdef POWER_SPECTRUM_FRAME_CHECK_EN
        chk("t4_err", pe0, 1);
        chk("t4_lasts", n_last, 2);
        chk("t4_last_idx", last_idx, 611);
`else
        chk("t4_err", pe0, 0);
        chk("t4_lasts", n_last, 1);
        chk("t4_last_idx", last_idx, 511);
`endif

        // Reset asserted mid-frame at beat 200.
        do_reset();
        for (int i = 0; i < 200; i++) send(i, i, 1'b0, -1, -1, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_valid_drop", pv0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++)
            send(i % 50, -(i % 30), i == N - 1, -1, -1, -1);
        idle(6);
        chk("t5_count", n_pop, 512);
        chk("t5_last_idx", last_idx, 511);
        chk("t5_err", pe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
